// File: rtl/alu_decode_stage.sv
// RV64I decode stage: turns fetched instructions into ALU control bundles,
// registered into an output register backed by a one-entry skid buffer.
module alu_decode_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_alu_opcodes,
  output logic [1:0]      out_a_sel,
  output logic            out_b_imm,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b1000,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_OR   = 4'b1100,
    ALU_AND  = 4'b1110
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    alu_op_e         alu;
    logic [1:0]      a_sel;
    logic            b_imm;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } bundle_t;

  function automatic alu_op_e alu_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [5:0]      f6;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_sh;
  logic            legal;
  bundle_t         dec, or_q, sk_q;
  logic            or_valid, sk_valid;
  logic            accept;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign f6     = in_instr[31:26];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u  = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
  assign imm_sh = {{(XLEN-6){1'b0}}, in_instr[25:20]};

  always_comb begin
    dec     = '0;
    legal   = 1'b1;
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    dec.rd  = in_instr[11:7];
    dec.pc  = in_pc;
    case (opcode)
      OPC_OP: begin
        dec.alu       = alu_from_f3(f3);
        dec.reg_write = 1'b1;
        if (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))
          dec.alu = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        else if (f7 != 7'h00)
          legal = 1'b0;
      end
      OPC_OP_IMM: begin
        dec.alu       = alu_from_f3(f3);
        dec.b_imm     = 1'b1;
        dec.reg_write = 1'b1;
        dec.imm       = imm_i;
        // Shifts carry a 6-bit shamt; the upper bits select logical/arithmetic.
        if (f3 == 3'b001 || f3 == 3'b101) begin
          dec.imm = imm_sh;
          if (f3 == 3'b101 && f6 == 6'h10)
            dec.alu = ALU_SRA;
          else if (f6 != 6'h00)
            legal = 1'b0;
        end
      end
      OPC_LOAD: begin
        dec.b_imm     = 1'b1;
        dec.imm       = imm_i;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.b_imm     = 1'b1;
        dec.imm       = imm_s;
        dec.mem_write = 1'b1;
      end
      OPC_LUI: begin
        dec.a_sel     = 2'b10;
        dec.b_imm     = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.a_sel     = 2'b01;
        dec.b_imm     = 1'b1;
        dec.imm       = imm_u;
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.alu       = ALU_ADD;
      dec.a_sel     = '0;
      dec.b_imm     = 1'b0;
      dec.imm       = '0;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.illegal   = 1'b1;
    end
  end

  assign in_ready = !sk_valid && !rst;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
      or_q     <= '0;
      sk_q     <= '0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (!or_valid || out_ready) begin
      if (sk_valid) begin
        or_q     <= sk_q;
        or_valid <= 1'b1;
        sk_valid <= accept;
        if (accept) sk_q <= dec;
      end else begin
        or_valid <= accept;
        if (accept) or_q <= dec;
      end
    end else if (accept) begin
      sk_valid <= 1'b1;
      sk_q     <= dec;
    end
  end

  assign out_valid       = or_valid;
  assign out_alu_opcodes = or_q.alu;
  assign out_a_sel       = or_q.a_sel;
  assign out_b_imm       = or_q.b_imm;
  assign out_imm         = or_q.imm;
  assign out_rs1         = or_q.rs1;
  assign out_rs2         = or_q.rs2;
  assign out_rd          = or_q.rd;
  assign out_reg_write   = or_q.reg_write;
  assign out_mem_read    = or_q.mem_read;
  assign out_mem_write   = or_q.mem_write;
  assign out_illegal     = or_q.illegal;
  assign out_pc          = or_q.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Bench for alu_decode_stage: directed vectors, handshake corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_imm, out_pc;
  logic [3:0]  out_alu_opcodes;
  logic [1:0]  out_a_sel;
  logic        out_b_imm, out_reg_write, out_mem_read, out_mem_write, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  int n_checks = 0;
  int n_pass   = 0;

  alu_decode_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_opcodes(out_alu_opcodes), .out_a_sel(out_a_sel), .out_b_imm(out_b_imm),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  alu;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic [63:0] imm;
    logic        imm_known;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, ill;
    logic [63:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [1:0]  a_sel;
    logic        b_imm;
    logic [63:0] imm;
    logic        chk_imm;
    logic        rw, mr, mw, ill;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference decode written from the ISA rules, mnemonic by mnemonic.
  function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [5:0] f6;
    logic ok;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25]; f6 = i[31:26];
    e = '{alu: 4'h0, a_sel: 2'b00, b_imm: 1'b0, imm: 64'h0, imm_known: 1'b0,
          rs1: i[19:15], rs2: i[24:20], rd: i[11:7], rw: 1'b0, mr: 1'b0, mw: 1'b0,
          ill: 1'b0, pc: pc};
    ok = 1'b1;
    case (op)
      7'b0110011: begin
        e.rw = 1'b1;
        case (f3)
          3'd0: e.alu = (f7 == 7'h20) ? 4'b0001 : 4'b0000;
          3'd1: e.alu = 4'b0010;
          3'd2: e.alu = 4'b0100;
          3'd3: e.alu = 4'b0110;
          3'd4: e.alu = 4'b1000;
          3'd5: e.alu = (f7 == 7'h20) ? 4'b1011 : 4'b1010;
          3'd6: e.alu = 4'b1100;
          default: e.alu = 4'b1110;
        endcase
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'b0010011: begin
        e.rw = 1'b1; e.b_imm = 1'b1; e.imm_known = 1'b1;
        e.imm = 64'(signed'(i[31:20]));
        case (f3)
          3'd0: e.alu = 4'b0000;
          3'd1: begin e.alu = 4'b0010; e.imm = 64'(i[25:20]); ok = (f6 == 6'h00); end
          3'd2: e.alu = 4'b0100;
          3'd3: e.alu = 4'b0110;
          3'd4: e.alu = 4'b1000;
          3'd5: begin
            e.alu = (f6 == 6'h10) ? 4'b1011 : 4'b1010;
            e.imm = 64'(i[25:20]);
            ok = (f6 == 6'h00) || (f6 == 6'h10);
          end
          3'd6: e.alu = 4'b1100;
          default: e.alu = 4'b1110;
        endcase
      end
      7'b0000011: begin
        e.b_imm = 1'b1; e.imm_known = 1'b1; e.imm = 64'(signed'(i[31:20]));
        e.mr = 1'b1; e.rw = 1'b1;
      end
      7'b0100011: begin
        e.b_imm = 1'b1; e.imm_known = 1'b1; e.mw = 1'b1;
        e.imm = 64'(signed'({i[31:25], i[11:7]}));
      end
      7'b0110111, 7'b0010111: begin
        e.a_sel = (op == 7'b0110111) ? 2'b10 : 2'b01;
        e.b_imm = 1'b1; e.imm_known = 1'b1; e.rw = 1'b1;
        e.imm = 64'(signed'({i[31:12], 12'h000}));
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.alu = 4'h0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.ill = 1'b1; e.imm_known = 1'b0;
    end
    return e;
  endfunction

  task automatic chk_bundle(input string tag, input exp_t e);
    chk({tag, ".alu"}, 64'(out_alu_opcodes), 64'(e.alu));
    chk({tag, ".rs"}, {49'h0, out_rs1, out_rs2, out_rd}, {49'h0, e.rs1, e.rs2, e.rd});
    chk({tag, ".flags"}, {60'h0, out_reg_write, out_mem_read, out_mem_write, out_illegal},
        {60'h0, e.rw, e.mr, e.mw, e.ill});
    chk({tag, ".pc"}, out_pc, e.pc);
    if (!e.ill) chk({tag, ".sel"}, {61'h0, out_a_sel, out_b_imm}, {61'h0, e.a_sel, e.b_imm});
    if (e.imm_known) chk({tag, ".imm"}, out_imm, e.imm);
  endtask

  task automatic send(input logic [31:0] instr, input logic [63:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
  endtask

  vec_t vecs[16];

  initial begin
    exp_t q[$];
    exp_t e;
    logic [31:0] ins;
    logic do_flush, acc, pop;

    vecs[0]  = '{32'h002081B3, 4'h0, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'h402081B3, 4'h1, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'h40335293, 4'hB, 2'b00, 1'b1, 64'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'hFFF00093, 4'h0, 2'b00, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h0020A423, 4'h0, 2'b00, 1'b1, 64'd8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{32'h00000000, 4'h0, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{32'h123450B7, 4'h0, 2'b10, 1'b1, 64'h12345000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'hFFFFF117, 4'h0, 2'b01, 1'b1, 64'hFFFFFFFFFFFFF000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'hFF813083, 4'h0, 2'b00, 1'b1, 64'hFFFFFFFFFFFFFFF8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32'h4020F1B3, 4'h0, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'h40309093, 4'h0, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h03F09093, 4'h2, 2'b00, 1'b1, 64'd63, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'hFFF0B093, 4'h6, 2'b00, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h0020E1B3, 4'hC, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32'h4020D1B3, 4'hB, 2'b00, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{32'h80335293, 4'h0, 2'b00, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.in_ready_low", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 64'(in_ready), 64'd1);
    chk("post_rst.out_valid", 64'(out_valid), 64'd0);
    chk("post_rst.payload", out_imm | out_pc | 64'(out_alu_opcodes) | 64'(out_reg_write), 64'd0);

    // Directed decode vectors, one at a time with execute always ready.
    out_ready = 1'b1;
    for (int unsigned v = 0; v < 16; v++) begin
      @(negedge clk);
      send(vecs[v].instr, 64'h1000 + 64'(v) * 4);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d.valid", v), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d.alu", v), 64'(out_alu_opcodes), 64'(vecs[v].alu));
      chk($sformatf("vec%0d.flags", v),
          {60'h0, out_reg_write, out_mem_read, out_mem_write, out_illegal},
          {60'h0, vecs[v].rw, vecs[v].mr, vecs[v].mw, vecs[v].ill});
      chk($sformatf("vec%0d.pc", v), out_pc, 64'h1000 + 64'(v) * 4);
      if (!vecs[v].ill)
        chk($sformatf("vec%0d.sel", v), {61'h0, out_a_sel, out_b_imm},
            {61'h0, vecs[v].a_sel, vecs[v].b_imm});
      if (vecs[v].chk_imm) chk($sformatf("vec%0d.imm", v), out_imm, vecs[v].imm);
    end
    @(negedge clk);

    // Backpressure: three back-to-back offers, only two absorbed.
    out_ready = 1'b0;
    send(32'h002081B3, 64'h2000); #1 chk("bp.ready0", 64'(in_ready), 64'd1);
    @(negedge clk);
    send(32'h402081B3, 64'h2004); #1 chk("bp.ready1", 64'(in_ready), 64'd1);
    @(negedge clk);
    send(32'h0020C1B3, 64'h2008); #1 chk("bp.ready2", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp.first.valid", 64'(out_valid), 64'd1);
    chk("bp.first.alu", 64'(out_alu_opcodes), 64'h0);
    chk("bp.first.rs", {49'h0, out_rs1, out_rs2, out_rd}, {49'h0, 5'd1, 5'd2, 5'd3});
    chk("bp.first.pc", out_pc, 64'h2000);
    @(negedge clk); #1;
    chk("bp.second.valid", 64'(out_valid), 64'd1);
    chk("bp.second.alu", 64'(out_alu_opcodes), 64'h1);
    chk("bp.second.pc", out_pc, 64'h2004);
    chk("bp.second.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); #1;
    chk("bp.drained.valid", 64'(out_valid), 64'd0);

    // Flush with both entries full and a new offer pending.
    @(negedge clk);
    out_ready = 1'b0;
    send(32'h002081B3, 64'h3000);
    @(negedge clk);
    send(32'h402081B3, 64'h3004);
    @(negedge clk);
    send(32'h0020C1B3, 64'h3008); flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.in_ready", 64'(in_ready), 64'd1);
    repeat (3) begin
      @(negedge clk); #1;
      chk("flush.stays_empty", 64'(out_valid), 64'd0);
    end

    // Reset mid-stream, then a clean decode.
    out_ready = 1'b0;
    send(32'h0020A423, 64'h4000);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("rstmid.pre_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.out_valid", 64'(out_valid), 64'd0);
    chk("rstmid.payload", out_imm | out_pc | 64'(out_mem_write), 64'd0);
    chk("rstmid.in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    send(32'h40335293, 64'h5000);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rstmid.next.valid", 64'(out_valid), 64'd1);
    chk_bundle("rstmid.next", model(32'h40335293, 64'h5000));
    @(negedge clk);

    // Randomized traffic against the queue model (entries held = OR + SK).
    for (int unsigned c = 0; c < 3000; c++) begin
      ins = $urandom;
      case ($urandom_range(0, 7))
        0: ins[6:0] = 7'b0110011;
        1: ins[6:0] = 7'b0010011;
        2: ins[6:0] = 7'b0000011;
        3: ins[6:0] = 7'b0100011;
        4: ins[6:0] = 7'b0110111;
        5: ins[6:0] = 7'b0010111;
        6: ins[6:0] = 7'b0110011;
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0: ins[31:25] = 7'h00;
        1: ins[31:25] = 7'h20;
        2: ins[31:26] = 6'h00;
        default: ;
      endcase
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = ins;
      in_pc     = {$urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 6);
      do_flush  = ($urandom_range(0, 99) < 3);
      flush     = do_flush;
      #1;
      chk("rand.out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("rand.in_ready", 64'(in_ready), 64'(q.size() < 2));
      if (out_valid && q.size() != 0) chk_bundle("rand", q[0]);
      acc = in_valid && (q.size() < 2);
      pop = out_ready && (q.size() != 0);
      if (do_flush) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (acc) begin
          e = model(in_instr, in_pc);
          q.push_back(e);
        end
      end
      @(negedge clk);
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
